// File: rtl/ysyx_22041211_iter_muldiv_if.sv
// Issue/result bus between the EXU and the iterative multiply/divide unit.
// The master side issues operands, takes results and flushes; the slave side is the unit.
interface ysyx_22041211_iter_muldiv_if #(
    parameter int DATA_LEN = 32
);
    logic                flush_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [2:0]          op_i;
    logic [DATA_LEN-1:0] src1_i;
    logic [DATA_LEN-1:0] src2_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [DATA_LEN-1:0] result_o;
    logic                busy_o;

    modport master (
        output flush_i, in_valid_i, op_i, src1_i, src2_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, busy_o
    );

    modport slave (
        input  flush_i, in_valid_i, op_i, src1_i, src2_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, busy_o
    );
endinterface

// File: rtl/ysyx_22041211_iter_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, signs applied at the end.
module ysyx_22041211_iter_muldiv #(
    parameter int DATA_LEN = 32,
    parameter int CNT_W    = 6
) (
    input logic                        clk,
    input logic                        rst_n,
    ysyx_22041211_iter_muldiv_if.slave bus
);

    localparam logic [DATA_LEN-1:0] MIN_VAL = {1'b1, {(DATA_LEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          op_q;
    logic                neg_q;
    logic [DATA_LEN-1:0] opnd_q;
    logic [DATA_LEN-1:0] hi_q;
    logic [DATA_LEN-1:0] lo_q;
    logic [DATA_LEN-1:0] result_q;

    // operand decode at issue
    logic                is_div, is_rem, s1_signed, s2_signed, neg1, neg2;
    logic                div_zero, div_ovf, accept;
    logic [DATA_LEN-1:0] mag1, mag2, special_res;

    // one iteration step
    logic [DATA_LEN:0]     mul_sum, div_shift, div_trial;
    logic [DATA_LEN-1:0]   hi_d, lo_d;

    // final sign/half selection
    logic [2*DATA_LEN-1:0] prod, prod_s;
    logic [DATA_LEN-1:0]   div_val, fix_res;

    // decode the incoming op: signedness, magnitudes, result sign and special cases
    always_comb begin
        is_div    = bus.op_i[2];
        is_rem    = bus.op_i[1];
        s1_signed = is_div ? ~bus.op_i[0] : (bus.op_i[1:0] == 2'b01 || bus.op_i[1:0] == 2'b10);
        s2_signed = is_div ? ~bus.op_i[0] : (bus.op_i[1:0] == 2'b01);
        neg1      = s1_signed & bus.src1_i[DATA_LEN-1];
        neg2      = s2_signed & bus.src2_i[DATA_LEN-1];
        mag1      = neg1 ? -bus.src1_i : bus.src1_i;
        mag2      = neg2 ? -bus.src2_i : bus.src2_i;
        div_zero  = is_div & (bus.src2_i == '0);
        div_ovf   = is_div & ~bus.op_i[0] & (bus.src1_i == MIN_VAL) & (bus.src2_i == '1);
        if (div_zero) begin
            special_res = is_rem ? bus.src1_i : '1;
        end else begin
            special_res = is_rem ? '0 : MIN_VAL;
        end
        accept = bus.in_valid_i & (state_q == IDLE) & ~bus.flush_i;
    end

    // one shift-add (multiply) or restoring-subtract (divide) step over {hi_q, lo_q}
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[DATA_LEN-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        if (op_q[2]) begin
            hi_d = div_trial[DATA_LEN] ? div_shift[DATA_LEN-1:0] : div_trial[DATA_LEN-1:0];
            lo_d = {lo_q[DATA_LEN-2:0], ~div_trial[DATA_LEN]};
        end else begin
            hi_d = mul_sum[DATA_LEN:1];
            lo_d = {mul_sum[0], lo_q[DATA_LEN-1:1]};
        end
    end

    // apply the result sign and pick product half or quotient/remainder
    always_comb begin
        prod    = {hi_q, lo_q};
        prod_s  = neg_q ? -prod : prod;
        div_val = op_q[1] ? hi_q : lo_q;
        if (op_q[2]) begin
            fix_res = neg_q ? -div_val : div_val;
        end else if (op_q[1:0] == 2'b00) begin
            fix_res = prod_s[DATA_LEN-1:0];
        end else begin
            fix_res = prod_s[2*DATA_LEN-1:DATA_LEN];
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic; flush overrides everything including a coincident accept
    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (accept) state_d = (div_zero | div_ovf) ? DONE : CALC;
                CALC: if (cnt_q == '0) state_d = FIX;
                FIX:  state_d = DONE;
                DONE: if (bus.out_ready_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // handshake outputs decoded from state
    always_comb begin
        bus.in_ready_o  = (state_q == IDLE);
        bus.out_valid_o = (state_q == DONE);
        bus.busy_o      = (state_q != IDLE);
        bus.result_o    = result_q;
    end

    // datapath: latch operands at accept, iterate in CALC, write result in FIX
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q   <= bus.op_i;
                        neg_q  <= (is_div & is_rem) ? neg1 : (neg1 ^ neg2);
                        hi_q   <= '0;
                        lo_q   <= is_div ? mag1 : mag2;
                        opnd_q <= is_div ? mag2 : mag1;
                        cnt_q  <= CNT_W'(DATA_LEN - 1);
                        if (div_zero | div_ovf) begin
                            result_q <= special_res;
                        end
                    end
                end
                CALC: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                FIX: begin
                    result_q <= fix_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_iter_muldiv.sv
// Self-checking bench for the iterative multiply/divide unit (DATA_LEN=32):
// directed corner cases, flush/reset/backpressure sequences and random ops vs a reference model.
module tb_ysyx_22041211_iter_muldiv;

    localparam logic [31:0] MIN_V = 32'h8000_0000;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    ysyx_22041211_iter_muldiv_if #(.DATA_LEN(32)) bus ();

    ysyx_22041211_iter_muldiv #(
        .DATA_LEN (32),
        .CNT_W    (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // free-running clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics written with plain 64-bit / int arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        int              ia;
        int              ib;
        logic [31:0]     r;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = signed'(a);
        ib = signed'(b);
        r  = '0;
        case (op)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = '1;
                else if (a == MIN_V && b == '1) r = MIN_V;
                else r = ia / ib;
            end
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == MIN_V && b == '1) r = '0;
                else r = ia % ib;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = MIN_V;
            3:       v = $urandom_range(0, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // issue one op from a negedge, check latency, busy window, result, optional backpressure, release
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int hold);
        int          exp_lat;
        int          lat;
        logic        rdy_low;
        logic        stable;
        logic [31:0] first;
        exp_lat = (op[2] && (b == 0 || (!op[0] && a == MIN_V && b == '1))) ? 1 : 34;
        bus.in_valid_i = 1'b1;
        bus.op_i       = op;
        bus.src1_i     = a;
        bus.src2_i     = b;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        bus.op_i       = 3'($urandom);
        bus.src1_i     = $urandom;
        bus.src2_i     = $urandom;
        lat     = 0;
        rdy_low = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.out_valid_o && bus.in_ready_o) rdy_low = 1'b0;
        end while (!bus.out_valid_o && lat < 200);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, bus.result_o, exp_res);
        check({tag, "_busy_rdy"}, {rdy_low, bus.in_ready_o, bus.busy_o}, 3'b101);
        if (hold > 0) begin
            first  = bus.result_o;
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (!bus.out_valid_o || bus.in_ready_o || bus.result_o !== first) stable = 1'b0;
            end
            check({tag, "_hold"}, stable, 1'b1);
        end
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        check({tag, "_release"}, {bus.out_valid_o, bus.in_ready_o}, 2'b01);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        seen;
        clk             = 1'b0;
        rst_n           = 1'b0;
        n_cmp           = 0;
        n_err           = 0;
        bus.flush_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.op_i        = '0;
        bus.src1_i      = '0;
        bus.src2_i      = '0;
        bus.out_ready_i = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_ctrl", {bus.busy_o, bus.in_ready_o, bus.out_valid_o}, 3'b010);
        check("reset_result", bus.result_o, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed values
        do_op("mul_7_m3",      3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        do_op("mulh_min_min",  3'd1, MIN_V,        MIN_V,         32'h4000_0000, 0);
        do_op("mulhu_ff_ff",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        do_op("mulhsu_ff_ff",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op("div_m7_2",      3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 0);
        do_op("rem_m7_2",      3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 0);
        do_op("divu_min_3",    3'd5, MIN_V,        32'd3,         32'h2AAA_AAAA, 0);
        do_op("div_5_0",       3'd4, 32'd5,        32'd0,         32'hFFFF_FFFF, 0);
        do_op("remu_5_0",      3'd7, 32'd5,        32'd0,         32'd5, 0);
        do_op("div_ovf",       3'd4, MIN_V,        32'hFFFF_FFFF, MIN_V, 0);
        do_op("rem_ovf",       3'd6, MIN_V,        32'hFFFF_FFFF, 32'h0, 0);
        do_op("mulh_min_m1",   3'd1, MIN_V,        32'hFFFF_FFFF, 32'h0, 0);
        do_op("bp_mul",        3'd0, 32'd1234,     32'd5678,      32'd7006652, 10);

        // flush in CALC cycle 5: no result may appear
        bus.in_valid_i = 1'b1;
        bus.op_i       = 3'd0;
        bus.src1_i     = 32'd9;
        bus.src2_i     = 32'd9;
        @(posedge clk);
        #1 bus.in_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush_calc", {bus.busy_o, bus.in_ready_o, bus.out_valid_o}, 3'b010);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid_o) seen = 1'b1;
        end
        check("flush_no_valid", seen, 1'b0);

        // reset while DONE holds a result
        bus.in_valid_i = 1'b1;
        bus.op_i       = 3'd4;
        bus.src1_i     = 32'd5;
        bus.src2_i     = 32'd0;
        @(posedge clk);
        #1 bus.in_valid_i = 1'b0;
        @(negedge clk);
        check("rst_done_pre", bus.out_valid_o, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_done_ctrl", {bus.busy_o, bus.in_ready_o, bus.out_valid_o}, 3'b010);
        check("rst_done_result", bus.result_o, 32'h0);
        do_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 0);

        // flush beats a coincident accept
        bus.in_valid_i = 1'b1;
        bus.flush_i    = 1'b1;
        bus.op_i       = 3'd0;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        bus.flush_i    = 1'b0;
        check("flush_vs_accept", {bus.busy_o, bus.in_ready_o}, 2'b01);

        // flush drops a pending result in DONE
        bus.in_valid_i = 1'b1;
        bus.op_i       = 3'd5;
        bus.src1_i     = 32'd3;
        bus.src2_i     = 32'd0;
        @(posedge clk);
        #1 bus.in_valid_i = 1'b0;
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush_done", {bus.out_valid_o, bus.in_ready_o}, 2'b01);

        // random ops against the reference model
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            do_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, ref_model(op, a, b),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
